// File: rtl/random_fill_gen.sv
// Multi-lane Galois-LFSR grid fill generator: LANES cells per beat, valid/ready stream, start/busy/done.
// Optional density threshold enabled by defining RANDOM_FILL_DENSITY_EN.
module random_fill_gen #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                LANES     = 8,
  parameter int                CELLS     = 1024,
  parameter int                DENSITY_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LFSR_W-1:0]    seed,
  input  logic                 seed_load,
  input  logic [DENSITY_W-1:0] density,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_data,
  output logic                 out_last
);

  localparam int               BEATS     = CELLS / LANES;
  localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             accept;
  logic             reseed;
  logic             launch;

  // A zero seed would lock the LFSR, so it is remapped to 1.
  function automatic logic [LFSR_W-1:0] seed_map(input logic [LFSR_W-1:0] v);
    return (v == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : v;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] st);
    return (st >> 1) ^ (st[0] ? TAPS : '0);
  endfunction

  assign accept = (state_q == S_RUN) && out_ready;
  assign reseed = (state_q == S_IDLE) && seed_load;
  assign launch = (state_q == S_IDLE) && start;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          beat_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end
      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef RANDOM_FILL_DENSITY_EN
  // Threshold is captured at launch so mid-fill changes cannot skew a grid.
  logic [DENSITY_W-1:0] density_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      density_q <= '0;
    end else if (launch) begin
      density_q <= density;
    end
  end
`else
  logic unused_density;
  assign unused_density = ^{density, launch};
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [LFSR_W-1:0] OFFS = LFSR_W'(gi);
    logic [LFSR_W-1:0] lane_q, lane_d;

    always_comb begin
      lane_d = lane_q;
      if (reseed) begin
        lane_d = seed_map(seed + OFFS);
      end else if (accept) begin
        lane_d = lfsr_step(lane_q);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= seed_map(SEED + OFFS);
      end else begin
        lane_q <= lane_d;
      end
    end

`ifdef RANDOM_FILL_DENSITY_EN
    assign out_data[gi] = (lane_q[DENSITY_W-1:0] < density_q);
`else
    assign out_data[gi] = lane_q[0];
`endif
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = (state_q == S_RUN);
  assign out_last  = (state_q == S_RUN) && (beat_cnt_q == LAST_BEAT);

endmodule
